imem_loader: RTL and testbench

- Write-side counterpart to the instruction memory: fills it with a program before the core runs.
- Accepts a byte stream over a valid/ready handshake and parses a framed image: a 16-bit word count, the program words, then an optional checksum.
- Assembles each 4-byte group into a 32-bit word and drives a one-word-per-pulse write port.
- Sits between the host/boot byte source and the instruction memory write port; the core is held off while busy=1.

---
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: parses a framed byte stream (16-bit LE word count, LE program
//   words, optional XOR checksum byte) and writes 32-bit words to the imem.
// Latency: one word write (mem_we) is registered on the edge that accepts its
//   4th byte. Backpressure: in_ready is low outside the header/data/checksum
//   states; an idle stream (in_valid=0) stalls the FSM indefinitely.
// Ports: clk, reset (async, active-low); start pulse; in_valid/in_ready/in_data
//   byte stream; mem_we/mem_addr/mem_wdata write port; busy, done, error
//   (sticky until next start), words_written.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_loader #(
  parameter int BASE_ADDR = 4,
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_HDR_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_FIN    = S_CHK;   // state entered once the payload ends
`else
  localparam logic [2:0] S_FIN    = S_DONE;
`endif

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] part_q, part_d;      // lanes 0..2 of the word being assembled
  logic [31:0] addr_q, addr_d;      // address of the next word to write
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        we_q, we_d;
  logic        active_q, active_d;  // drives both in_ready and busy
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] nwr_q, nwr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        take;
  logic [15:0] hdr_cnt;
  logic [31:0] last_addr;

  assign take      = in_valid & active_q;
  assign hdr_cnt   = {in_data, cnt_q[7:0]};
  // Address of the final word for the count in the header; only meaningful
  // for hdr_cnt != 0, which is checked first.
  assign last_addr = 32'(BASE_ADDR) + (32'(hdr_cnt) - 32'd1) * 32'(ADDR_STEP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    part_d    = part_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    nwr_d     = nwr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_LO;
          nwr_d   = '0;
          addr_d  = 32'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_HDR_LO: begin
        if (take) begin
          cnt_d[7:0] = in_data;
          state_d    = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (take) begin
          cnt_d = hdr_cnt;
          if (hdr_cnt == 16'd0) begin
            state_d = S_FIN;
          end else if (last_addr > 32'(MEM_DEPTH - 1)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            lane_d  = 2'd0;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: part_d[7:0]   = in_data;
            2'd1: part_d[15:8]  = in_data;
            2'd2: part_d[23:16] = in_data;
            default: begin
              we_d      = 1'b1;
              wr_data_d = {in_data, part_q};
              wr_addr_d = addr_q;
              addr_d    = addr_q + 32'(ADDR_STEP);
              nwr_d     = nwr_q + 16'd1;
              if (nwr_q + 16'd1 == cnt_q) state_d = S_FIN;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (take) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
    // Header and data bytes feed the checksum; the checksum byte itself does not.
    if (take && (state_q == S_HDR_LO || state_q == S_HDR_HI || state_q == S_DATA))
      csum_d = csum_q ^ in_data;
`endif
    active_d = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state_d == S_CHK)
`endif
               ;
    // Sticky flags simply track the terminal state; a start leaves it.
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lane_q    <= '0;
      part_q    <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      nwr_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      part_q    <= part_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      we_q      <= we_d;
      active_q  <= active_d;
      done_q    <= done_d;
      err_q     <= err_d;
      nwr_q     <= nwr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign in_ready      = active_q;
  assign busy          = active_q;
  assign mem_we        = we_q;
  assign mem_addr      = wr_addr_q;
  assign mem_wdata     = wr_data_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_written = nwr_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven, hand-written and randomized frames for
//   imem_loader, compared against a frame-level reference model.
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

  localparam int BASE  = 4;
  localparam int DEPTH = 64;
  localparam int STEP  = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_pass   = 0;

  typedef logic [31:0] wq_t[$];
  typedef logic [7:0]  bq_t[$];
  logic [63:0] wr_q[$];   // {addr, data} of every observed write

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] seed;
    int          gap;
    bit          exp_done;
    bit          exp_err;
    logic [15:0] exp_nwr;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_first_data;
  } vec_t;

  imem_loader #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .ADDR_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("in_ready_wait", 32'(in_ready), 32'd1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL %s/end_timeout: done=%0b error=%0b, expected one of them set", nm, done, error);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "/in_ready"}, 32'(in_ready), 0);
    chk({nm, "/mem_we"}, 32'(mem_we), 0);
    chk({nm, "/busy"}, 32'(busy), 0);
    chk({nm, "/done"}, 32'(done), 0);
    chk({nm, "/error"}, 32'(error), 0);
    chk({nm, "/mem_addr"}, mem_addr, 0);
    chk({nm, "/mem_wdata"}, mem_wdata, 0);
    chk({nm, "/words_written"}, 32'(words_written), 0);
  endtask

  // Reference rules: a nonzero count is legal when its last word address fits.
  function automatic bit legal_count(input int c);
    return (c == 0) || (BASE + (c - 1) * STEP <= DEPTH - 1);
  endfunction

  function automatic bq_t make_frame(input logic [15:0] cnt, input wq_t w, input bit bad);
    bq_t b;
    logic [7:0] x;
    logic [31:0] wd;
    b.push_back(cnt[7:0]);
    b.push_back(cnt[15:8]);
    if (legal_count(int'(cnt))) begin
      for (int i = 0; i < int'(cnt); i++) begin
        wd = w[i];
        for (int k = 0; k < 4; k++) b.push_back(wd[8*k +: 8]);
      end
      if (CHK_EN) begin
        x = 8'h00;
        foreach (b[j]) x = x ^ b[j];
        b.push_back(bad ? ~x : x);
      end
    end
    return b;
  endfunction

  function automatic wq_t make_words(input int n, input logic [31:0] seed);
    wq_t w;
    for (int i = 0; i < n && i < 64; i++) w.push_back(seed + 32'(i) * 32'h01010101);
    return w;
  endfunction

  // gap < 0 selects a random 0..2 idle cycles before each byte.
  task automatic run_frame(input string nm, input logic [15:0] cnt, input wq_t w,
                           input int gap, input bit bad);
    bq_t b;
    bit ok, exp_err;
    int nexp, g;
    logic [63:0] e;
    b = make_frame(cnt, w, bad);
    ok = legal_count(int'(cnt));
    exp_err = !ok || (CHK_EN && bad);
    nexp = ok ? int'(cnt) : 0;
    wr_q.delete();
    pulse_start();
    foreach (b[j]) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send_byte(b[j], g);
    end
    wait_end(nm);
    tick();
    chk({nm, "/done"}, 32'(done), 32'(!exp_err));
    chk({nm, "/error"}, 32'(error), 32'(exp_err));
    chk({nm, "/busy"}, 32'(busy), 0);
    chk({nm, "/in_ready"}, 32'(in_ready), 0);
    chk({nm, "/words_written"}, 32'(words_written), 32'(nexp));
    chk({nm, "/n_writes"}, 32'(wr_q.size()), 32'(nexp));
    for (int i = 0; i < wr_q.size() && i < nexp; i++) begin
      e = {32'(BASE + i * STEP), w[i]};
      chk($sformatf("%s/wr%0d", nm, i), wr_q[i][63:32] ^ e[63:32] | (wr_q[i][31:0] ^ e[31:0]), 0);
    end
  endtask

  initial begin
    vec_t tbl[6];
    wq_t  w;
    bq_t  b;
    logic [15:0] rc;

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("idle");

    tbl[0] = '{16'd1,   32'h00410033, 0, 1'b1, 1'b0, 16'd1,  32'd4,  32'h00410033};
    tbl[1] = '{16'd3,   32'h03020100, 1, 1'b1, 1'b0, 16'd3,  32'd12, 32'h03020100};
    tbl[2] = '{16'd16,  32'h00000000, 0, 1'b0, 1'b1, 16'd0,  32'd0,  32'd0};
    tbl[3] = '{16'd0,   32'h00000000, 0, 1'b1, 1'b0, 16'd0,  32'd0,  32'd0};
    tbl[4] = '{16'd15,  32'hF0E0D0C0, 2, 1'b1, 1'b0, 16'd15, 32'd60, 32'hF0E0D0C0};
    tbl[5] = '{16'd256, 32'h00000000, 0, 1'b0, 1'b1, 16'd0,  32'd0,  32'd0};

    for (int t = 0; t < 6; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      w = make_words(int'(tbl[t].cnt), tbl[t].seed);
      run_frame(nm, tbl[t].cnt, w, tbl[t].gap, 1'b0);
      chk({nm, "/tbl_done"}, 32'(done), 32'(tbl[t].exp_done));
      chk({nm, "/tbl_error"}, 32'(error), 32'(tbl[t].exp_err));
      chk({nm, "/tbl_nwr"}, 32'(words_written), 32'(tbl[t].exp_nwr));
      if (tbl[t].exp_nwr != 0 && wr_q.size() != 0) begin
        chk({nm, "/tbl_first_data"}, wr_q[0][31:0], tbl[t].exp_first_data);
        chk({nm, "/tbl_last_addr"}, wr_q[wr_q.size()-1][63:32], tbl[t].exp_last_addr);
      end
    end

    // start while busy is ignored; start after done clears the sticky status
    w = '{32'h11223344, 32'hA1B2C3D4};
    b = make_frame(16'd2, w, 1'b0);
    wr_q.delete();
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    chk("ready_after_start", 32'(in_ready), 1);
    for (int j = 0; j < 4; j++) send_byte(b[j], 0);
    pulse_start();
    for (int j = 4; j < b.size(); j++) send_byte(b[j], 0);
    wait_end("ign_start");
    tick();
    chk("ign_start/done", 32'(done), 1);
    chk("ign_start/nwr", 32'(words_written), 2);
    chk("ign_start/n_writes", 32'(wr_q.size()), 2);
    if (wr_q.size() == 2) chk("ign_start/wr1", wr_q[1][63:32] ^ 32'd8 | (wr_q[1][31:0] ^ 32'hA1B2C3D4), 0);
    pulse_start();
    chk("restart/done", 32'(done), 0);
    chk("restart/nwr", 32'(words_written), 0);
    chk("restart/busy", 32'(busy), 1);
    // This frame's own start pulse lands in HDR_LO and is ignored.
    run_frame("after_restart", 16'd1, '{32'hDEADBEEF}, 0, 1'b0);

    // reset in the middle of the second word
    w = '{32'h55667788, 32'h99AABBCC};
    b = make_frame(16'd2, w, 1'b0);
    wr_q.delete();
    pulse_start();
    for (int j = 0; j < 8; j++) send_byte(b[j], 0);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (3) tick();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("mid_reset/n_writes", 32'(wr_q.size()), 1);
    if (wr_q.size() != 0) chk("mid_reset/wr0_data", wr_q[0][31:0], 32'h55667788);
    run_frame("post_reset", 16'd1, '{32'h0BADF00D}, 0, 1'b0);

    // inverted checksum (only affects outcome when the checksum is built in)
    run_frame("bad_chk", 16'd2, '{32'h01234567, 32'h89ABCDEF}, 0, 1'b1);

    for (int r = 0; r < 25; r++) begin
      rc = 16'($urandom_range(0, 17));
      w.delete();
      for (int i = 0; i < int'(rc); i++) w.push_back($urandom);
      run_frame($sformatf("rnd%0d", r), rc, w, -1, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
